// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmit shift register.
// Optional start-handshake timeout is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int DATA_SIZE      = 7,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0] data_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         ack_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [DATA_SIZE-1:0]         tsr_d_o,
  output logic                         tsr_start_o,
  input  logic                         tsr_busy_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, BUSY} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [DATA_SIZE-1:0] tsr_d_q, tsr_d_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 win_vld;
  logic [IW-1:0]        win_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Search starts one past the previous winner and wraps, so every requester rotates to top priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld && req_i[(int'(last_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tsr_d_d = tsr_d_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    last_d  = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld && !tsr_busy_i) begin
          state_d          = START;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          tsr_d_d          = data_i[win_idx*DATA_SIZE +: DATA_SIZE];
          ack_d            = 1'b1;
          last_d           = win_idx;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end
      end
      START: begin
        if (tsr_busy_i) begin
          state_d = BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // Frame is dropped, not retried; the requester must ask again.
          state_d = IDLE;
          grant_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      BUSY: begin
        if (!tsr_busy_i) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      tsr_d_q <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tsr_d_q <= tsr_d_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      last_q  <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign ack_o       = ack_q;
  assign done_o      = done_q;
  assign tsr_d_o     = tsr_d_q;
  assign tsr_start_o = (state_q == START);
`ifdef UART_ARB_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a behavioural tsr model plus a grant/payload scoreboard.
module tb_uart_tx_arbiter;
  localparam int DS = 7;
  localparam int NR = 4;
  localparam int BUSY_LEN = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req_i;
  logic [NR*DS-1:0]   data_i;
  logic [NR-1:0]      grant_o;
  logic               ack_o, done_o, err_o, tsr_start_o, tsr_busy_i;
  logic [DS-1:0]      tsr_d_o;

  logic               force_mode, man_busy, model_busy;
  int                 bcnt;
  int                 tests = 0, fails = 0;
  int                 ack_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [NR+DS-1:0]   exp_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_SIZE(DS), .NUM_REQ(NR), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i),
    .grant_o(grant_o), .ack_o(ack_o), .done_o(done_o), .err_o(err_o),
    .tsr_d_o(tsr_d_o), .tsr_start_o(tsr_start_o), .tsr_busy_i(tsr_busy_i)
  );

  // tsr model: sees tx_start, goes busy for BUSY_LEN cycles, then idles.
  initial begin model_busy = 1'b0; bcnt = 0; end
  always @(posedge clk) begin
    if (!model_busy && tsr_start_o) begin
      model_busy <= 1'b1;
      bcnt       <= BUSY_LEN;
    end else if (model_busy) begin
      if (bcnt == 1) model_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end
  assign tsr_busy_i = force_mode ? man_busy : model_busy;

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [NR+DS-1:0] e;
    if (ack_o || done_o || err_o) begin
      tests++;
      assert ($countones({ack_o, done_o, err_o}) == 1)
        else begin fails++; $error("FAIL pulse_excl: ack/done/err=%b expected one-hot", {ack_o, done_o, err_o}); end
    end
    if (ack_o) begin
      ack_cnt++;
      tests++;
      assert (exp_q.size() > 0)
        else begin fails++; $error("FAIL sb_underflow: unexpected ack grant=%b data=%h", grant_o, tsr_d_o); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        assert ({grant_o, tsr_d_o} === e)
          else begin fails++; $error("FAIL sb_ack: got grant=%b data=%h expected grant=%b data=%h",
                                     grant_o, tsr_d_o, e[NR+DS-1:DS], e[DS-1:0]); end
      end
    end
    if (done_o) done_cnt++;
    if (err_o)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin fails++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp); end
  endtask

  task automatic wait_ack(input int max, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ack_o && n < max);
    chk(tag, {31'b0, ack_o}, 32'd1);
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_o && n < max);
    chk(tag, {31'b0, done_o}, 32'd1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int a0, d0, err_seen, start_low;
    reset = 1'b0; req_i = '0; data_i = '0; force_mode = 1'b0; man_busy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", tsr_start_o, 0);
    chk("rst_tsr_d", tsr_d_o, 0);
    reset = 1'b1;

    // Single frame from requester 0
    data_i[0*DS +: DS] = 7'h7D;
    req_i = 4'b0001;
    exp_q.push_back({4'b0001, 7'h7D});
    @(negedge clk);
    chk("t1_ack_latency", ack_o, 1);
    chk("t1_grant", grant_o, 4'b0001);
    chk("t1_start", tsr_start_o, 1);
    req_i = '0;
    wait_done(20, "t1_done");
    chk("t1_grant_clr", grant_o, 0);
    chk("t1_start_low", tsr_start_o, 0);
    chk("t1_tsr_d_hold", tsr_d_o, 7'h7D);

    // All four requesting: 0,1,2,3,0
    @(negedge clk);
    do_reset(1);
    for (int k = 0; k < NR; k++) data_i[k*DS +: DS] = DS'(8'h11 * (k + 1));
    @(negedge clk);
    a0 = ack_cnt; d0 = done_cnt;
    exp_q.push_back({4'b0001, 7'h11});
    exp_q.push_back({4'b0010, 7'h22});
    exp_q.push_back({4'b0100, 7'h33});
    exp_q.push_back({4'b1000, 7'h44});
    exp_q.push_back({4'b0001, 7'h11});
    req_i = 4'b1111;
    for (int f = 0; f < 5; f++) wait_done(30, "t2_done");
    req_i = '0;
    @(negedge clk);
    chk("t2_ack_cnt", ack_cnt - a0, 5);
    chk("t2_done_cnt", done_cnt - d0, 5);

    // Request while tsr busy in IDLE
    force_mode = 1'b1; man_busy = 1'b1;
    data_i[2*DS +: DS] = 7'h5A;
    @(negedge clk);
    a0 = ack_cnt;
    req_i = 4'b0100;
    repeat (5) @(negedge clk);
    chk("t3_no_ack", ack_cnt - a0, 0);
    chk("t3_no_grant", grant_o, 0);
    exp_q.push_back({4'b0100, 7'h5A});
    man_busy = 1'b0; force_mode = 1'b0;
    wait_ack(5, "t3_ack");
    chk("t3_grant", grant_o, 4'b0100);
    req_i = '0;
    wait_done(20, "t3_done");

    // Reset while BUSY
    @(negedge clk);
    data_i[1*DS +: DS] = 7'h15;
    exp_q.push_back({4'b0010, 7'h15});
    req_i = 4'b0010;
    wait_ack(5, "t4_ack");
    req_i = '0;
    for (int n = 0; n < 10 && tsr_start_o; n++) @(negedge clk);
    chk("t4_in_busy", tsr_start_o, 0);
    d0 = done_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_rst_grant", grant_o, 0);
    chk("t4_rst_ack", ack_o, 0);
    chk("t4_rst_done", done_o, 0);
    chk("t4_rst_err", err_o, 0);
    chk("t4_rst_start", tsr_start_o, 0);
    chk("t4_rst_tsr_d", tsr_d_o, 0);
    reset = 1'b1;
    data_i[0*DS +: DS] = 7'h2A;
    exp_q.push_back({4'b0001, 7'h2A});
    req_i = 4'b0011;
    wait_ack(20, "t4_ack_after_rst");
    req_i = '0;
    wait_done(20, "t4_done");
    @(negedge clk);
    chk("t4_one_done", done_cnt - d0, 1);

    // Start handshake never answered
    force_mode = 1'b1; man_busy = 1'b0;
    data_i[3*DS +: DS] = 7'h63;
    exp_q.push_back({4'b1000, 7'h63});
    req_i = 4'b1000;
    wait_ack(5, "t5_ack");
    req_i = '0;
`ifdef UART_ARB_TIMEOUT_EN
    err_seen = 0; start_low = 0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (err_o) err_seen = 1;
      if (!tsr_start_o) start_low = 1;
    end
    chk("t5_no_early_err", err_seen, 0);
    chk("t5_start_held", start_low, 0);
    @(negedge clk);
    chk("t5_err", err_o, 1);
    chk("t5_start_drop", tsr_start_o, 0);
    chk("t5_grant_clr", grant_o, 0);
    @(negedge clk);
    chk("t5_idle_start", tsr_start_o, 0);
    chk("t5_err_pulse", err_o, 0);
    force_mode = 1'b0;
`else
    err_seen = 0; start_low = 0;
    repeat (20) begin
      @(negedge clk);
      if (err_o) err_seen = 1;
      if (!tsr_start_o) start_low = 1;
    end
    chk("t5_no_err", err_seen, 0);
    chk("t5_start_held", start_low, 0);
    man_busy = 1'b1;
    repeat (2) @(negedge clk);
    man_busy = 1'b0;
    wait_done(5, "t5_done");
    force_mode = 1'b0;
    chk("t5_err_cnt", err_cnt, 0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
